// File: rtl/alu_ctrl_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, ALU op/ext codes
// and instruction field positions.
package alu_ctrl_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_MOV = 4'hD;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int EXT_MSB = 7;
  localparam int EXT_LSB = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;

  function automatic logic is_alu_code(input logic [3:0] code);
    return (code == OP_AND) || (code == OP_OR)  || (code == OP_XOR) ||
           (code == OP_ADD) || (code == OP_SUB) || (code == OP_CMP) ||
           (code == OP_MOV);
  endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_insn_field_decode.sv
// Combinational decode of an instruction word into ALU opcode, extended
// immediate, immediate-mux select, write-allowed and illegal flags.
module insn_field_decode
  import alu_ctrl_sequencer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] insn_i,
  output logic [7:0]        opcode_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              imm_sel_o,
  output logic              wr_ok_o,
  output logic              illegal_o
);

  logic [3:0] op;
  logic [3:0] ext;
  logic [7:0] imm8;

  assign op   = insn_i[OP_MSB:OP_LSB];
  assign ext  = insn_i[EXT_MSB:EXT_LSB];
  assign imm8 = insn_i[IMM_MSB:0];

  always_comb begin
    opcode_o  = 8'h00;
    imm_o     = '0;
    imm_sel_o = 1'b0;
    wr_ok_o   = 1'b0;
    illegal_o = 1'b0;
    if (op == OP_NOP) begin
      opcode_o  = {4'h0, ext};
      illegal_o = !(is_alu_code(ext) || (ext == OP_NOP));
      wr_ok_o   = is_alu_code(ext) && (ext != OP_CMP);
    end else begin
      opcode_o  = {op, 4'h0};
      imm_sel_o = 1'b1;
      illegal_o = !is_alu_code(op);
      wr_ok_o   = is_alu_code(op) && (op != OP_CMP);
      // Logical ops treat imm8 as a bit mask; arithmetic ops treat it as signed.
      if ((op == OP_AND) || (op == OP_OR) || (op == OP_XOR))
        imm_o = {{(DATA_W-8){1'b0}}, imm8};
      else
        imm_o = {{(DATA_W-8){imm8[7]}}, imm8};
    end
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Instruction sequencer: accepts one instruction per handshake and walks it
// through IDLE -> EXEC -> WB, driving the register-file/ALU control bundle.
module alu_ctrl_sequencer
  import alu_ctrl_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] enable,
  output logic [SEL_W-1:0]  control1,
  output logic [SEL_W-1:0]  control2,
  output logic              imm_control,
  output logic [DATA_W-1:0] immediate,
  output logic [7:0]        opcode,
  output logic              buff_en,
  output logic              done,
  output logic              illegal
);

  state_t            state_q;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              ready_q;
  logic [DATA_W-1:0] enable_q;
  logic [SEL_W-1:0]  ctl1_q, ctl2_q;
  logic              immc_q;
  logic [DATA_W-1:0] imm_q;
  logic [7:0]        opc_q;
  logic              buff_q, done_q, ill_q;

  logic              accept;
  logic [7:0]        dec_opcode;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_imm_sel, dec_wr_ok, dec_illegal;
  logic [SEL_W-1:0]  sel1_d, sel2_d;
  logic [DATA_W-1:0] onehot_d;

  assign accept  = (state_q == ST_IDLE) && ready_q && instr_valid;
  // Decode the word that will sit in the instruction register next cycle, so
  // the registered outputs line up with the state they belong to.
  assign instr_d = accept ? instr : instr_q;

  assign sel1_d   = {{(SEL_W-4){1'b0}}, instr_d[RD_MSB:RD_LSB]};
  assign sel2_d   = {{(SEL_W-4){1'b0}}, instr_d[RS_MSB:RS_LSB]};
  assign onehot_d = DATA_W'(1) << instr_d[RD_MSB:RD_LSB];

  insn_field_decode #(.DATA_W(DATA_W)) u_dec (
    .insn_i    (instr_d),
    .opcode_o  (dec_opcode),
    .imm_o     (dec_imm),
    .imm_sel_o (dec_imm_sel),
    .wr_ok_o   (dec_wr_ok),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      ready_q  <= 1'b0;
      enable_q <= '0;
      ctl1_q   <= '0;
      ctl2_q   <= '0;
      immc_q   <= 1'b0;
      imm_q    <= '0;
      opc_q    <= '0;
      buff_q   <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_EXEC;
            instr_q <= instr_d;
            ready_q <= 1'b0;
            ctl1_q  <= sel1_d;
            ctl2_q  <= sel2_d;
            immc_q  <= dec_imm_sel;
            imm_q   <= dec_imm;
            opc_q   <= dec_opcode;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          state_q  <= ST_WB;
          buff_q   <= 1'b1;
          done_q   <= 1'b1;
          ill_q    <= dec_illegal;
          enable_q <= dec_wr_ok ? onehot_d : '0;
        end
        default: begin
          state_q  <= ST_IDLE;
          ready_q  <= (state_q == ST_WB);
          enable_q <= '0;
          ctl1_q   <= '0;
          ctl2_q   <= '0;
          immc_q   <= 1'b0;
          imm_q    <= '0;
          opc_q    <= '0;
          buff_q   <= 1'b0;
          done_q   <= 1'b0;
          ill_q    <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = ready_q && reset;
  assign enable      = enable_q;
  assign control1    = ctl1_q;
  assign control2    = ctl2_q;
  assign imm_control = immc_q;
  assign immediate   = imm_q;
  assign opcode      = opc_q;
  assign buff_en     = buff_q;
  assign done        = done_q;
  assign illegal     = ill_q;

endmodule
